gate_response_checker: RTL and testbench
========================================

GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, cycles each vector is held before sampling; values below 1 behave as 1.
REQ-002 SHALL have parameter ERR_W, default 4, width of the error counter.
REQ-003 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to run a sweep.
REQ-006 SHALL have ports a_o, b_o  output  1 each  stimulus driven to the gates under test.
REQ-007 SHALL have ports y_nand, y_nor, y_xor, y_xnor  input  1 each  responses of the gates under test.
REQ-008 SHALL have port busy  output  1  high while a sweep runs.
REQ-009 SHALL have port done  output  1  high from sweep completion until the next accepted start or reset.
REQ-010 SHALL have port pass  output  1  equals done AND (err_cnt == 0).
REQ-011 SHALL have port err_cnt  output  ERR_W  count of failing vectors in the current or last sweep.

Function
REQ-012 SHALL implement the FSM IDLE -> SETTLE -> CHECK -> (SETTLE | DONE), with DONE -> SETTLE on start.
REQ-013 SHALL accept start only in IDLE or DONE; start while busy SHALL be ignored.
REQ-014 On accepted start: vec=0, err_cnt=0, done=0, busy=1, next state SETTLE.
REQ-015 SHALL drive a_o=vec[1] and b_o=vec[0] in SETTLE and CHECK; sweep order is 00, 01, 10, 11.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles; CHECK SHALL last exactly one cycle.
REQ-017 In CHECK, SHALL compare {y_xnor,y_xor,y_nor,y_nand} against the golden mask for vec; any bit mismatch counts as one failing vector.
REQ-018 err_cnt SHALL increment by one per failing vector and saturate at 2^ERR_W-1.
REQ-019 After CHECK with vec==3, SHALL enter DONE (busy=0, done=1); otherwise it SHALL set vec=vec+1 and return to SETTLE.
REQ-020 Latency from the cycle start is sampled to done=1 SHALL be 4*(SETTLE_CYCLES+1) cycles.
REQ-021 In IDLE and DONE, a_o and b_o SHALL be 0.

Reset
REQ-022 On rst: state=IDLE, vec=0, a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0, plus the capture outputs at 0 when enabled.
REQ-023 rst SHALL take priority over start; rst mid-sweep SHALL abort the sweep with no done pulse.

Configuration
REQ-024 Macro GATE_CHK_CAPTURE_EN, when defined, SHALL add outputs fail_vec[1:0] and fail_mask[3:0] holding the vector and XOR-mismatch mask of the first failing vector in the sweep, both cleared on accepted start.
REQ-025 When GATE_CHK_CAPTURE_EN is undefined, those ports and registers SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-026 Package gate_chk_pkg SHALL hold the FSM state enum and the 4x4 golden truth-table constant: vec 0:1110? no, by bit order {xnor,xor,nor,nand}: vec0=1011, vec1=0101, vec2=0101, vec3=1000.
REQ-027 One sub-module, gate_golden_model, SHALL map vec to the expected 4-bit mask combinationally.

Verification
REQ-028 Correct gates, SETTLE_CYCLES=2, start pulse -> done=1 exactly 12 cycles later, pass=1, err_cnt=0, with a_o/b_o stepping 00,01,10,11.
REQ-029 y_nand stuck at 1 -> only vec 3 fails; err_cnt=1, pass=0, and with capture fail_vec=3, fail_mask=0001.
REQ-030 All four responses inverted, ERR_W=2 -> 4 failing vectors; err_cnt saturates at 3.
REQ-031 start reasserted mid-sweep -> ignored; sweep timing and result unchanged.
REQ-032 rst asserted during vec 2 SETTLE -> all outputs 0 the next cycle; a new start gives a full clean sweep with pass=1.
REQ-033 start in DONE after a failing sweep, with gates fixed -> err_cnt cleared, pass=1 after 12 cycles.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared FSM state encoding and golden truth table for the gate response checker.
// Mask bit order everywhere is {xnor, xor, nor, nand}; vector bit 1 drives a, bit 0 drives b.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Packed table, vec 3 in the top nibble down to vec 0 in the bottom nibble.
  localparam logic [15:0] GOLDEN_TT = {4'b1000, 4'b0101, 4'b0101, 4'b1011};

  function automatic logic [3:0] golden_mask(input logic [1:0] vec);
    return GOLDEN_TT[{vec, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Expected {xnor, xor, nor, nand} response for a 2-bit stimulus vector.
// Purely combinational, no flow control.
module gate_golden_model
  import gate_chk_pkg::*;
(
  input  logic [1:0] i_vec,
  output logic [3:0] o_mask
);

  assign o_mask = golden_mask(i_vec);

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps a/b through 00,01,10,11 and checks NAND/NOR/XOR/XNOR responses; done after 4*(SETTLE_CYCLES+1) cycles.
// start is ignored while busy; GATE_CHK_CAPTURE_EN adds first-failure capture outputs fail_vec/fail_mask.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             y_nand,
  input  logic             y_nor,
  input  logic             y_xor,
  input  logic             y_xnor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef GATE_CHK_CAPTURE_EN
  ,
  output logic [1:0]       fail_vec,
  output logic [3:0]       fail_mask
`endif
);

  localparam int S_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W = (S_EFF > 1) ? $clog2(S_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(S_EFF - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           r_state;
  logic [1:0]       r_vec;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0] w_gold;
  logic [3:0] w_resp;
  logic [3:0] w_diff;
  logic       w_fail;
  logic [1:0] w_vec_nxt;

  gate_golden_model u_golden (
    .i_vec  (r_vec),
    .o_mask (w_gold)
  );

  assign w_resp    = {y_xnor, y_xor, y_nor, y_nand};
  assign w_diff    = w_resp ^ w_gold;
  assign w_fail    = |w_diff;
  assign w_vec_nxt = r_vec + 2'd1;
  assign pass      = done && (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vec     <= 2'd0;
      r_cnt     <= '0;
      a_o       <= 1'b0;
      b_o       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
`ifdef GATE_CHK_CAPTURE_EN
      fail_vec  <= 2'd0;
      fail_mask <= 4'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state   <= ST_SETTLE;
            r_vec     <= 2'd0;
            r_cnt     <= '0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_cnt   <= '0;
`ifdef GATE_CHK_CAPTURE_EN
            fail_vec  <= 2'd0;
            fail_mask <= 4'd0;
`endif
          end
        end
        ST_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (w_fail) begin
            if (err_cnt != ERR_MAX) begin
              err_cnt <= err_cnt + ERR_W'(1);
            end
`ifdef GATE_CHK_CAPTURE_EN
            // err_cnt never wraps, so zero means no earlier failure this sweep.
            if (err_cnt == '0) begin
              fail_vec  <= r_vec;
              fail_mask <= w_diff;
            end
`endif
          end
          if (r_vec == 2'd3) begin
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            a_o     <= 1'b0;
            b_o     <= 1'b0;
          end else begin
            r_state <= ST_SETTLE;
            r_vec   <= w_vec_nxt;
            r_cnt   <= '0;
            a_o     <= w_vec_nxt[1];
            b_o     <= w_vec_nxt[0];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboarded bench: two checker instances (ERR_W 4 and 2) share stimulus against modelled gates with injectable faults.
// Expected results are queued at start and popped when done rises.
module tb_gate_response_checker;

  localparam int S = 2;
  localparam int LAT = 4 * (S + 1);

  typedef struct {
    int err4;
    int err2;
    int fv;
    int fm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   fault = 0;

  logic a4, b4, busy4, done4, pass4;
  logic a2, b2, busy2, done2, pass2;
  logic [3:0] err4;
  logic [1:0] err2;
  logic [3:0] r4, r2;
`ifdef GATE_CHK_CAPTURE_EN
  logic [1:0] fv4, fv2;
  logic [3:0] fm4, fm2;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Ideal gate outputs, bit order {xnor, xor, nor, nand}.
  function automatic logic [3:0] ideal(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b)};
  endfunction

  function automatic logic [3:0] gates(input logic a, input logic b, input int f);
    logic [3:0] r;
    r = ideal(a, b);
    if (f == 1) r[0] = 1'b1;
    if (f == 2) r = ~r;
    return r;
  endfunction

  always_comb r4 = gates(a4, b4, fault);
  always_comb r2 = gates(a2, b2, fault);

  gate_response_checker #(.SETTLE_CYCLES(S), .ERR_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a_o(a4), .b_o(b4),
    .y_nand(r4[0]), .y_nor(r4[1]), .y_xor(r4[2]), .y_xnor(r4[3]),
    .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4)
`ifdef GATE_CHK_CAPTURE_EN
    , .fail_vec(fv4), .fail_mask(fm4)
`endif
  );

  gate_response_checker #(.SETTLE_CYCLES(S), .ERR_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .start(start), .a_o(a2), .b_o(b2),
    .y_nand(r2[0]), .y_nor(r2[1]), .y_xor(r2[2]), .y_xnor(r2[3]),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef GATE_CHK_CAPTURE_EN
    , .fail_vec(fv2), .fail_mask(fm2)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input int f);
    exp_t e;
    int n;
    logic [3:0] d;
    n = 0;
    e.fv = 0;
    e.fm = 0;
    for (int v = 0; v < 4; v++) begin
      d = gates(v[1], v[0], f) ^ ideal(v[1], v[0]);
      if (d != 4'd0) begin
        if (n == 0) begin
          e.fv = v;
          e.fm = int'(d);
        end
        n++;
      end
    end
    e.err4 = (n > 15) ? 15 : n;
    e.err2 = (n > 3) ? 3 : n;
    return e;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_a"}, int'(a4), 0);
    chk({tag, "_b"}, int'(b4), 0);
    chk({tag, "_busy"}, int'(busy4), 0);
    chk({tag, "_done"}, int'(done4), 0);
    chk({tag, "_pass"}, int'(pass4), 0);
    chk({tag, "_err"}, int'(err4), 0);
    chk({tag, "_err_w2"}, int'(err2), 0);
`ifdef GATE_CHK_CAPTURE_EN
    chk({tag, "_fv"}, int'(fv4), 0);
    chk({tag, "_fm"}, int'(fm4), 0);
`endif
  endtask

  // Runs one sweep; restart_at >= 0 re-pulses start that many cycles into it.
  task automatic run_sweep(input int f, input int restart_at, input string tag);
    exp_t e;
    int k;
    fault = f;
    sb.push_back(predict(f));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done4 && k < LAT + 8) begin
      if (k < LAT) begin
        chk({tag, "_busy"}, int'(busy4), 1);
        chk({tag, "_ab"}, int'({a4, b4}), k / (S + 1));
        chk({tag, "_ab_w2"}, int'({a2, b2}), k / (S + 1));
      end
      start = (k == restart_at);
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    chk({tag, "_latency"}, k, LAT);
    chk({tag, "_done"}, int'(done4), 1);
    chk({tag, "_done_w2"}, int'(done2), 1);
    chk({tag, "_busy_end"}, int'(busy4), 0);
    chk({tag, "_ab_end"}, int'({a4, b4}), 0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err"}, int'(err4), e.err4);
      chk({tag, "_err_w2"}, int'(err2), e.err2);
      chk({tag, "_pass"}, int'(pass4), (e.err4 == 0) ? 1 : 0);
      chk({tag, "_pass_w2"}, int'(pass2), (e.err2 == 0) ? 1 : 0);
`ifdef GATE_CHK_CAPTURE_EN
      chk({tag, "_fv"}, int'(fv4), e.fv);
      chk({tag, "_fm"}, int'(fm4), e.fm);
      chk({tag, "_fv_w2"}, int'(fv2), e.fv);
`endif
    end
    // DONE holds until the next accepted start.
    @(negedge clk);
    chk({tag, "_done_hold"}, int'(done4), 1);
  endtask

  initial begin
    int seen_done;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    run_sweep(0, -1, "clean");
    run_sweep(1, -1, "nand_stuck1");
    run_sweep(0, -1, "restart_from_done");
    run_sweep(2, -1, "all_inverted");
    run_sweep(0, 4, "start_while_busy");

    // Abort during vec 2 SETTLE.
    fault = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * (S + 1)) @(negedge clk);
    chk("abort_pre_ab", int'({a4, b4}), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("abort");
    seen_done = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (done4 || busy4) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);
    run_sweep(0, -1, "after_abort");

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
